// File: rtl/frequency_jump_event_logger_pkg.sv
// Shared constants and event layout for the frequency jump event logger.
// Host-side decoders use the same field offsets and word width.
package frequency_jump_event_logger_pkg;

    localparam int unsigned FIFO_DEPTH_LOG2 = 4;
    localparam int unsigned LINE_W          = 12;
    localparam int unsigned FRAME_W         = 16;
    localparam int unsigned COUNT_W         = 8;
    localparam int unsigned EVT_W           = FRAME_W + LINE_W;
    localparam int unsigned FRAME_LSB       = LINE_W;
    localparam int unsigned LINE_LSB        = 0;

    typedef struct packed {
        logic [FRAME_W-1:0] frame;
        logic [LINE_W-1:0]  line;
    } evt_t;

    // Increment that sticks at all-ones.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/frequency_jump_event_logger_if.sv
// Valid/ready event read port between the logger (master) and the host (slave).
interface frequency_jump_event_logger_if;
    import frequency_jump_event_logger_pkg::*;

    logic [EVT_W-1:0] event_data;
    logic             event_valid;
    logic             event_ready;

    modport master (output event_data, output event_valid, input event_ready);
    modport slave  (input event_data, input event_valid, output event_ready);

endinterface

// File: rtl/frequency_jump_event_logger_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with registered head, full and empty.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [WIDTH-1:0]      head_q, head_d;
    logic                  pop_ok, push_ok;
    logic [DEPTH_LOG2-1:0] wr_idx, rd_idx_d;

    assign pop_ok   = pop_i & ~empty_q;
    assign push_ok  = push_i & (~full_q | pop_ok);
    assign wr_idx   = wr_ptr_q[DEPTH_LOG2-1:0];
    assign rd_idx_d = rd_ptr_d[DEPTH_LOG2-1:0];

    // Next pointers, flags and the head word as it will read after this edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = ((wr_ptr_d - rd_ptr_d) == PTR_W'(DEPTH));
        head_d   = '0;
        if (!empty_d) begin
            if (push_ok && (wr_idx == rd_idx_d)) begin
                head_d = push_data_i;
            end else begin
                head_d = mem_q[rd_idx_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign head_o  = head_q;

endmodule

// File: rtl/frequency_jump_event_logger.sv
// Turns jump_detected rising edges into frame/line tagged events, queues them,
// and keeps per-frame jump statistics plus a sticky overflow indication.
module frequency_jump_event_logger
    import frequency_jump_event_logger_pkg::*;
(
    input  logic                      pixel_clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      fval,
    input  logic                      lval,
    input  logic                      jump_detected,
    frequency_jump_event_logger_if.master evt,
    output logic [COUNT_W-1:0]        jumps_in_frame,
    output logic [COUNT_W-1:0]        last_frame_jumps,
    output logic                      overflow,
    output logic [COUNT_W-1:0]        dropped_events,
    input  logic                      overflow_clear
);

    logic               fval_dly_q, lval_dly_q, jump_dly_q;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [COUNT_W-1:0] jif_q, jif_d;
    logic [COUNT_W-1:0] lfj_q, lfj_d;
    logic               ovf_q, ovf_d;
    logic [COUNT_W-1:0] drops_q, drops_d;

    logic               jump_evt, fval_rise, fval_fall, lval_fall;
    logic               fifo_full, fifo_empty, pop, drop;
    logic [EVT_W-1:0]   head;
    evt_t               tag;

    assign jump_evt  = jump_detected & ~jump_dly_q & enable;
    assign fval_rise = fval & ~fval_dly_q;
    assign fval_fall = ~fval & fval_dly_q;
    assign lval_fall = ~lval & lval_dly_q;
    assign pop       = ~fifo_empty & evt.event_ready;
    assign drop      = jump_evt & fifo_full & ~pop;
    assign tag       = '{frame: frame_q, line: line_q};

    sync_fifo_fwft #(
        .WIDTH      (EVT_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i       (pixel_clock),
        .rst_i       (reset),
        .push_i      (jump_evt),
        .push_data_i (tag),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    // Line/frame indices and jump statistics; everything here holds while disabled.
    always_comb begin
        line_d  = line_q;
        frame_d = frame_q;
        jif_d   = jif_q;
        lfj_d   = lfj_q;
        ovf_d   = ovf_q;
        drops_d = drops_q;
        if (enable) begin
            if (fval_rise) begin
                line_d = '0;
            end else if (lval_fall && fval) begin
                line_d = line_q + LINE_W'(1);
            end
            if (fval_fall) begin
                frame_d = frame_q + FRAME_W'(1);
                lfj_d   = jump_evt ? sat_inc(jif_q) : jif_q;
                jif_d   = '0;
            end else if (jump_evt) begin
                jif_d = sat_inc(jif_q);
            end
        end
        // A drop in the same cycle as a clear leaves exactly one drop recorded.
        if (drop) begin
            ovf_d   = 1'b1;
            drops_d = overflow_clear ? COUNT_W'(1) : sat_inc(drops_q);
        end else if (overflow_clear) begin
            ovf_d   = 1'b0;
            drops_d = '0;
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            fval_dly_q <= 1'b0;
            lval_dly_q <= 1'b0;
            jump_dly_q <= 1'b0;
            line_q     <= '0;
            frame_q    <= '0;
            jif_q      <= '0;
            lfj_q      <= '0;
            ovf_q      <= 1'b0;
            drops_q    <= '0;
        end else begin
            fval_dly_q <= fval;
            lval_dly_q <= lval;
            jump_dly_q <= jump_detected;
            line_q     <= line_d;
            frame_q    <= frame_d;
            jif_q      <= jif_d;
            lfj_q      <= lfj_d;
            ovf_q      <= ovf_d;
            drops_q    <= drops_d;
        end
    end

    assign evt.event_valid = ~fifo_empty;
    assign evt.event_data  = head;
    assign jumps_in_frame   = jif_q;
    assign last_frame_jumps = lfj_q;
    assign overflow         = ovf_q;
    assign dropped_events   = drops_q;

endmodule

// File: doc/frequency_jump_event_logger.md
Name: frequency_jump_event_logger

Overview:
- Sits directly downstream of the frequency jump detector in the pixel-clock domain. It consumes the detector's jump_detected level, turns each rising edge into one event, tags the event with frame and line indices, and queues it in a small FIFO.
- The FIFO is read by the control/host side through a valid/ready interface.
- The block also keeps per-frame jump statistics and a sticky overflow indication.

Parameters:
- FIFO_DEPTH_LOG2, 4, log2 of event FIFO depth (16 entries).
- LINE_W, 12, width of the line index field.
- FRAME_W, 16, width of the frame index field.
- COUNT_W, 8, width of the per-frame jump counters and the drop counter.

Ports:
- pixel_clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  capture and counter update enable.
- fval  in  1  frame valid from the camera interface.
- lval  in  1  line valid from the camera interface.
- jump_detected  in  1  level output of the jump detector.
- event_data  out  FRAME_W+LINE_W  head event: {frame_index, line_index}.
- event_valid  out  1  FIFO non-empty.
- event_ready  in  1  consumer accepts the head event.
- jumps_in_frame  out  COUNT_W  running count for the current frame.
- last_frame_jumps  out  COUNT_W  count latched at the end of the previous frame.
- overflow  out  1  sticky; set when an event is dropped.
- dropped_events  out  COUNT_W  saturating count of dropped events.
- overflow_clear  in  1  clears overflow and dropped_events.

Behaviour:
- Reset values:
  - event_valid=0; event_data=0.
  - jumps_in_frame=0; last_frame_jumps=0.
  - overflow=0; dropped_events=0.
  - FIFO empty; line and frame counters 0; all edge-detect registers 0.
- Edge detection: fval, lval and jump_detected are each registered once (_d copies).
  - jump_evt = jump_detected & ~jump_d & enable.
  - A level held high for many cycles yields exactly one event.
- Line index:
  - Cleared on the fval rising edge.
  - Incremented (wrapping) on the lval falling edge while fval=1 and enable=1.
  - An event tags the line index value current in the cycle jump_evt is asserted.
- Frame index: incremented (wrapping at 2^FRAME_W) on the fval falling edge while enable=1.
- Latency: jump_evt in cycle N is written at the end of N; event_valid=1 from cycle N+1 when the FIFO was empty.
- FIFO: first-word-fall-through.
  - event_data is valid whenever event_valid=1 and is stable until popped.
  - Pop = event_valid & event_ready. event_ready while empty is ignored.
- Full with a same-cycle pop and push: the pop happens first and the push is accepted; no drop.
- Full with no pop: the event is dropped.
  - overflow<=1.
  - dropped_events increments, saturating at all-ones.
  - The FIFO contents are unchanged.
- overflow_clear=1 clears overflow and dropped_events. A drop in the same cycle wins: overflow=1 and dropped_events=1.
- jumps_in_frame:
  - Incremented (saturating) on each jump_evt, whether the event is queued or dropped.
  - On the fval falling edge: last_frame_jumps <= jumps_in_frame (+1 if jump_evt in the same cycle, saturating) and jumps_in_frame <= 0.
- enable=0:
  - No events are generated.
  - Line and frame counters and jumps_in_frame hold.
  - The FIFO read side keeps operating; edge-detect registers still update, so a level already high when enable rises produces no event.
- Reset mid-operation: the FIFO is flushed (pending events lost) and every output returns to its reset value the cycle after reset is sampled high.
- Pointers are FIFO_DEPTH_LOG2+1 bits wide, with the extra bit used for full/empty disambiguation. Wrap-around must not corrupt ordering.

Decomposition:
- Shared header: event field offsets (FRAME_LSB = LINE_W, LINE_LSB = 0) and the word width, so host-side decoders use the same constants.
- One sub-module: sync_fifo_fwft (parameterised width/depth; push, pop, full, empty, head data). Push-on-full-with-pop is handled inside it.
- Edge detection, counters and statistics stay in the top module.

Test Plan:
- fval frame with 3 lines; jump_detected held high for 40 cycles during line 1 of frame 0 -> exactly one event 0x0000_001 (frame 0, line 1); event_valid rises one cycle after the jump_detected rising edge.
- 3 separate jump pulses in one frame, then fval falls -> last_frame_jumps=3, jumps_in_frame=0; 3 events popped in order with matching line indices.
- event_ready=0 with 20 pulses into a depth-16 FIFO -> 16 queued, overflow=1, dropped_events=4, jumps_in_frame=20. Pulse overflow_clear -> overflow=0, dropped_events=0.
- FIFO full, event_ready=1 and jump_evt in the same cycle -> no drop; occupancy stays 16; overflow stays 0.
- enable=0 across a whole frame containing jumps -> no events, frame index unchanged; re-enable and jump -> frame index continues from its previous value.
- Assert reset while 5 events are queued -> event_valid=0 next cycle and all counters 0; a new jump after reset is logged as frame 0, line 0.
